// File: rtl/vga_timing_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen_pkg
//  Description : Shared mode constants, field widths and helpers for the VGA
//                raster timing generator (1280x1024@60 default mode).
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_gen_pkg;

  // Counter geometry: 11-bit raster counters, totals must fit in 2048.
  localparam int c_CNT_W   = 11;
  localparam int c_EXT_W   = c_CNT_W + 1;
  localparam int c_CNT_MAX = 2048;

  // Colour fields on the pins: {R,G,B}, 4 bits each.
  localparam int c_RGB_W = 4;
  localparam int c_PIX_W = 3 * c_RGB_W;

  // Default mode: 1280x1024@60, 108 MHz pixel clock.
  localparam int c_DEF_H_VISIBLE = 1280;
  localparam int c_DEF_H_FRONT   = 48;
  localparam int c_DEF_H_SYNC    = 112;
  localparam int c_DEF_H_BACK    = 248;
  localparam int c_DEF_V_VISIBLE = 1024;
  localparam int c_DEF_V_FRONT   = 1;
  localparam int c_DEF_V_SYNC    = 3;
  localparam int c_DEF_V_BACK    = 38;

  // Per-pixel timing flags carried alongside the colour read latency.
  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
  } timing_bits_t;

  localparam int c_TB_W = $bits(timing_bits_t);

  // lo <= cnt < hi, evaluated one bit wider so hi may equal 2048.
  function automatic logic in_window(input logic [c_EXT_W-1:0] cnt,
                                     input logic [c_EXT_W-1:0] lo,
                                     input logic [c_EXT_W-1:0] hi);
    return (cnt >= lo) && (cnt < hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_delay.sv
`default_nettype none
// ============================================================================
//  Module      : sync_delay
//  Description : Width/depth parameterised shift register with enable and
//                asynchronous reset to RESET_VAL. DEPTH 0 is a wire.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_delay #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      // No storage: clock, reset and enable are intentionally unused here.
      logic w_unused;
      assign w_unused = clk ^ rst ^ en;
      assign dout     = din;
    end else begin : g_shift
      logic [WIDTH-1:0] r_stage [DEPTH];

      // Advance every stage by one on each enabled edge.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) r_stage[i] <= RESET_VAL;
        end else if (en) begin
          r_stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
      end

      assign dout = r_stage[DEPTH-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : Raster counters, sync generation, colour blanking and pin
//                register for the VGA port, plus frame start/end pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int   H_VISIBLE = c_DEF_H_VISIBLE,
  parameter int   H_FRONT   = c_DEF_H_FRONT,
  parameter int   H_SYNC    = c_DEF_H_SYNC,
  parameter int   H_BACK    = c_DEF_H_BACK,
  parameter int   V_VISIBLE = c_DEF_V_VISIBLE,
  parameter int   V_FRONT   = c_DEF_V_FRONT,
  parameter int   V_SYNC    = c_DEF_V_SYNC,
  parameter int   V_BACK    = c_DEF_V_BACK,
  parameter logic SYNC_POL  = 1'b1,
  parameter int   RD_LAT    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_en,
  output logic [c_CNT_W-1:0] x,
  output logic [c_CNT_W-1:0] y,
  output logic               active,
  input  logic [c_PIX_W-1:0] rgb_in,
  output logic [c_RGB_W-1:0] vga_r,
  output logic [c_RGB_W-1:0] vga_g,
  output logic [c_RGB_W-1:0] vga_b,
  output logic               hsync,
  output logic               vsync,
  output logic               frame_start,
  output logic               frame_end
);

  localparam int c_H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int c_V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [c_CNT_W-1:0] c_ONE      = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_H_LAST   = c_CNT_W'(c_H_TOTAL - 1);
  localparam logic [c_CNT_W-1:0] c_V_LAST   = c_CNT_W'(c_V_TOTAL - 1);
  localparam logic [c_CNT_W-1:0] c_V_VIS_LS = c_CNT_W'(V_VISIBLE - 1);

  localparam logic [c_EXT_W-1:0] c_H_VIS   = c_EXT_W'(H_VISIBLE);
  localparam logic [c_EXT_W-1:0] c_V_VIS   = c_EXT_W'(V_VISIBLE);
  localparam logic [c_EXT_W-1:0] c_HS_LO   = c_EXT_W'(H_VISIBLE + H_FRONT);
  localparam logic [c_EXT_W-1:0] c_HS_HI   = c_EXT_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [c_EXT_W-1:0] c_VS_LO   = c_EXT_W'(V_VISIBLE + V_FRONT);
  localparam logic [c_EXT_W-1:0] c_VS_HI   = c_EXT_W'(V_VISIBLE + V_FRONT + V_SYNC);

  // Reject modes that do not fit the 11-bit counters or the read path.
  generate
    if (c_H_TOTAL > c_CNT_MAX || c_V_TOTAL > c_CNT_MAX) begin : g_bad_total
      $error("vga_timing_gen: H_TOTAL or V_TOTAL exceeds 2048");
    end
    if (RD_LAT < 0 || RD_LAT > 3) begin : g_bad_lat
      $error("vga_timing_gen: RD_LAT must be 0..3");
    end
  endgenerate

  logic [c_CNT_W-1:0] r_h;
  logic [c_CNT_W-1:0] r_v;
  logic               w_h_wrap;
  logic               w_v_wrap;
  timing_bits_t       w_now;
  timing_bits_t       w_dly;

  assign w_h_wrap = (r_h == c_H_LAST);
  assign w_v_wrap = (r_v == c_V_LAST);

  // Raster counters: h every enabled edge, v on each h wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h <= '0;
      r_v <= '0;
    end else if (pix_en) begin
      if (w_h_wrap) begin
        r_h <= '0;
        r_v <= w_v_wrap ? '0 : r_v + c_ONE;
      end else begin
        r_h <= r_h + c_ONE;
      end
    end
  end

  // Pulses are set on the edge entering the target coordinate and are
  // cleared on the following clk edge whether or not pix_en is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
    end else begin
      frame_start <= pix_en && w_h_wrap && w_v_wrap;
      frame_end   <= pix_en && w_h_wrap && (r_v == c_V_VIS_LS);
    end
  end

  // Flags for the coordinate currently on x/y; syncs are active-high here.
  assign w_now.active = in_window({1'b0, r_h}, '0, c_H_VIS) &&
                        in_window({1'b0, r_v}, '0, c_V_VIS);
  assign w_now.hsync  = in_window({1'b0, r_h}, c_HS_LO, c_HS_HI);
  assign w_now.vsync  = in_window({1'b0, r_v}, c_VS_LO, c_VS_HI);

  // Hold the flags back by the colour read latency.
  sync_delay #(
    .WIDTH     (c_TB_W),
    .DEPTH     (RD_LAT),
    .RESET_VAL ('0)
  ) u_sync_delay (
    .clk  (clk),
    .rst  (rst),
    .en   (pix_en),
    .din  (w_now),
    .dout (w_dly)
  );

  // Pin register: blank colour outside the visible area, apply polarity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_r <= '0;
      vga_g <= '0;
      vga_b <= '0;
      hsync <= ~SYNC_POL;
      vsync <= ~SYNC_POL;
    end else if (pix_en) begin
      {vga_r, vga_g, vga_b} <= w_dly.active ? rgb_in : '0;
      hsync <= w_dly.hsync ^ ~SYNC_POL;
      vsync <= w_dly.vsync ^ ~SYNC_POL;
    end
  end

  assign x      = r_h;
  assign y      = r_v;
  assign active = w_now.active;

endmodule
`default_nettype wire
